// File: rtl/pulse_guard.sv
// Gate-pulse guard: input glitch filter, on-time limiter with truncation count,
// enforced minimum off-time, and a fail-safe FAULT state driven by link health.
module pulse_guard #(
    parameter int unsigned FILT_CYC    = 2,
    parameter int unsigned MAX_ON_CYC0 = 2000,
    parameter int unsigned MAX_ON_CYC1 = 4000,
    parameter int unsigned MAX_ON_CYC2 = 8000,
    parameter int unsigned MAX_ON_CYC3 = 16000,
    parameter int unsigned MIN_OFF_CYC = 4000,
    parameter int unsigned LINK_OK_CYC = 40000
) (
    input  logic       i_clk,
    input  logic       i_res,
    input  logic       i_pls,
    input  logic       i_link_ok,
    input  logic [1:0] i_max_on_sel,
    output logic       o_pls,
    output logic       o_trunc,
    output logic       o_fault,
    output logic [7:0] o_trunc_cnt
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ON       = 2'd1;
    localparam logic [1:0] ST_OFF_HOLD = 2'd2;
    localparam logic [1:0] ST_FAULT    = 2'd3;

    localparam logic [3:0]  FILT_LAST = 4'(FILT_CYC - 1);
    localparam logic [15:0] LIM0      = 16'(MAX_ON_CYC0);
    localparam logic [15:0] LIM1      = 16'(MAX_ON_CYC1);
    localparam logic [15:0] LIM2      = 16'(MAX_ON_CYC2);
    localparam logic [15:0] LIM3      = 16'(MAX_ON_CYC3);
    localparam logic [15:0] OFF_MIN   = 16'(MIN_OFF_CYC);
    localparam logic [15:0] LINK_LAST = 16'(LINK_OK_CYC - 1);

    logic        flt_q, flt_d;
    logic [3:0]  flt_cnt_q, flt_cnt_d;
    logic [1:0]  state_q, state_d;
    logic [15:0] on_cnt_q, on_cnt_d;
    logic [15:0] off_cnt_q, off_cnt_d;
    logic [15:0] link_cnt_q, link_cnt_d;
    logic [15:0] lim_q, lim_d;
    logic        trunc_q, trunc_d;
    logic [7:0]  trunc_cnt_q, trunc_cnt_d;
    logic [15:0] sel_lim;

    // Filter counts consecutive samples that disagree with the current level.
    // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        flt_d     = flt_q;
        flt_cnt_d = '0;
        if (i_pls != flt_q) begin
            if (flt_cnt_q == FILT_LAST) begin
                flt_d = i_pls;
            end else begin
                flt_cnt_d = flt_cnt_q + 4'd1;
            end
        end
    end

    always_comb begin
        sel_lim = LIM0;
        case (i_max_on_sel)
            2'b00:   sel_lim = LIM0;
            2'b01:   sel_lim = LIM1;
            2'b10:   sel_lim = LIM2;
            default: sel_lim = LIM3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        on_cnt_d    = on_cnt_q;
        off_cnt_d   = off_cnt_q;
        link_cnt_d  = link_cnt_q;
        lim_d       = lim_q;
        trunc_d     = 1'b0;
        trunc_cnt_d = trunc_cnt_q;

        // Link loss overrides everything, including a truncation due this cycle.
        if (!i_link_ok) begin
            state_d    = ST_FAULT;
            link_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (flt_q) begin
                        state_d  = ST_ON;
                        on_cnt_d = 16'd1;
                        lim_d    = sel_lim;
                    end
                end
                ST_ON: begin
                    if (!flt_q) begin
                        state_d   = ST_OFF_HOLD;
                        off_cnt_d = 16'd1;
                    end else if (on_cnt_q == lim_q) begin
                        state_d   = ST_OFF_HOLD;
                        off_cnt_d = 16'd1;
                        trunc_d   = 1'b1;
                        if (trunc_cnt_q != 8'hFF) begin
                            trunc_cnt_d = trunc_cnt_q + 8'd1;
                        end
                    end else begin
                        on_cnt_d = on_cnt_q + 16'd1;
                    end
                end
                ST_OFF_HOLD: begin
                    if (off_cnt_q >= OFF_MIN) begin
                        if (!flt_q) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        off_cnt_d = off_cnt_q + 16'd1;
                    end
                end
                default: begin
                    // Current good sample counts toward the required run.
                    if (link_cnt_q >= LINK_LAST) begin
                        if (!flt_q) begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        link_cnt_d = link_cnt_q + 16'd1;
                    end
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_res) begin
            flt_q       <= 1'b0;
            flt_cnt_q   <= '0;
            state_q     <= ST_FAULT;
            on_cnt_q    <= '0;
            off_cnt_q   <= '0;
            link_cnt_q  <= '0;
            lim_q       <= '0;
            trunc_q     <= 1'b0;
            trunc_cnt_q <= '0;
        end else begin
            flt_q       <= flt_d;
            flt_cnt_q   <= flt_cnt_d;
            state_q     <= state_d;
            on_cnt_q    <= on_cnt_d;
            off_cnt_q   <= off_cnt_d;
            link_cnt_q  <= link_cnt_d;
            lim_q       <= lim_d;
            trunc_q     <= trunc_d;
            trunc_cnt_q <= trunc_cnt_d;
        end
    end

    assign o_pls       = (state_q == ST_ON);
    assign o_fault     = (state_q == ST_FAULT);
    assign o_trunc     = trunc_q;
    assign o_trunc_cnt = trunc_cnt_q;

endmodule
